// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a shared memory port: 1-cycle grant latency, address held until mem_ready.
// Requesters hold req until their ack. Optional BUSY timeout with err pulse under ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic             req0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] addr0,
  input  logic             mem_ready,
  output logic             mem_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic             select,
  output logic             ack1,
  output logic             ack0,
`ifdef ARB_TIMEOUT_EN
  output logic             busy,
  output logic             err
`else
  output logic             busy
`endif
);

  if (2**TO_W <= TIMEOUT) begin : g_bad_timeout_cfg
    $error("mem_port_arbiter: TO_W too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               mem_en_q, mem_en_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic               select_q, select_d;
  logic               ack1_q, ack1_d;
  logic               ack0_q, ack0_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;
  logic               grant;
  logic               finish;
`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    select_d   = select_q;
    ack1_d     = 1'b0;
    ack0_d     = 1'b0;
    busy_d     = busy_q;
    last_d     = last_q;
    grant      = 1'b0;
    finish     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester that did not win last time goes first.
          grant      = (req0 && req1) ? ~last_q : req1;
          select_d   = grant;
          mem_addr_d = grant ? addr1 : addr0;
          mem_en_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = BUSY;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        finish = mem_ready;
`ifdef ARB_TIMEOUT_EN
        if (!mem_ready) begin
          if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            finish = 1'b1;
            err_d  = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
`endif
        if (finish) begin
          mem_en_d = 1'b0;
          ack1_d   = select_q;
          ack0_d   = ~select_q;
          last_d   = select_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      select_q   <= 1'b0;
      ack1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      select_q   <= select_d;
      ack1_q     <= ack1_d;
      ack0_q     <= ack0_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign select   = select_q;
  assign ack1     = ack1_q;
  assign ack0     = ack0_q;
  assign busy     = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign err      = err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboard of expected grants, checked when acks appear.
module tb_mem_port_arbiter;
  localparam int WIDTH = 16;
`ifdef ARB_TIMEOUT_EN
  localparam int TIMEOUT = 4;
`else
  localparam int TIMEOUT = 15;
`endif
  localparam int TO_W = 4;

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] addr;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e, p;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req1 = 1'b0, req0 = 1'b0, mem_ready = 1'b0;
  logic [WIDTH-1:0] addr1 = '0, addr0 = '0;
  logic             mem_en, select, ack1, ack0, busy;
  logic [WIDTH-1:0] mem_addr;
  logic             err_w;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req0(req0), .addr1(addr1), .addr0(addr0),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_addr(mem_addr), .select(select),
    .ack1(ack1), .ack0(ack0),
`ifdef ARB_TIMEOUT_EN
    .busy(busy), .err(err_w)
`else
    .busy(busy)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign err_w = 1'b0;
`endif

  task automatic test_reset();
    logic [WIDTH+5:0] obs;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      req0 = 1'($urandom); req1 = 1'($urandom); mem_ready = 1'($urandom);
      addr0 = WIDTH'($urandom); addr1 = WIDTH'($urandom);
    end
    @(negedge clk);
    obs = {mem_en, select, ack1, ack0, busy, err_w, mem_addr};
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL reset_hold: got %h want 0", obs); end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    obs = {mem_en, select, ack1, ack0, busy, err_w, mem_addr};
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL reset_idle: got %h want 0", obs); end
  endtask

  task automatic test_single();
    req0 = 1'b1; addr0 = 16'h1234; mem_ready = 1'b0;
    p = '{sel: 1'b0, addr: 16'h1234, err: 1'b0}; exp_q.push_back(p);
    @(negedge clk);
    n_cmp++;
    if ({mem_en, select, busy, ack1, ack0} !== 5'b10100) begin
      n_bad++; $display("FAIL single_grant: got %b want 10100", {mem_en, select, busy, ack1, ack0});
    end
    n_cmp++;
    if (mem_addr !== 16'h1234) begin n_bad++; $display("FAIL single_addr: got %h want 1234", mem_addr); end
    @(negedge clk);
    n_cmp++;
    if ({mem_en, ack1, ack0} !== 3'b100) begin
      n_bad++; $display("FAIL single_hold: got %b want 100", {mem_en, ack1, ack0});
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, busy} !== 2'b01) begin
      n_bad++; $display("FAIL single_done: got %b want 01", {mem_en, busy});
    end
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL single_sb: queue empty at ack");
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({ack1, ack0} !== {e.sel, ~e.sel}) begin
        n_bad++; $display("FAIL single_ack: got %b want %b", {ack1, ack0}, {e.sel, ~e.sel});
      end
    end
    req0 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, busy, ack1, ack0} !== 4'b0000) begin
      n_bad++; $display("FAIL single_pulse: got %b want 0000", {mem_en, busy, ack1, ack0});
    end
  endtask

  task automatic test_back_to_back();
    int   acks = 0;
    int   grants = 0;
    int   last_cyc = 0;
    logic prev_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr0 = 16'hA000; addr1 = 16'hB111; req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p.sel = k[0]; p.addr = k[0] ? 16'hB111 : 16'hA000; p.err = 1'b0;
      exp_q.push_back(p);
    end
    for (int cyc = 0; cyc < 30 && acks < 4; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if ((ack0 && ack1) || ((ack0 || ack1) && mem_en)) begin
        n_bad++; $display("FAIL b2b_ack_excl: ack1=%b ack0=%b mem_en=%b", ack1, ack0, mem_en);
      end
      if (mem_en && !prev_en && exp_q.size() != 0) begin
        n_cmp++;
        if ({select, mem_addr} !== {exp_q[0].sel, exp_q[0].addr}) begin
          n_bad++; $display("FAIL b2b_grant: got %b/%h want %b/%h", select, mem_addr, exp_q[0].sel, exp_q[0].addr);
        end
        if (grants > 0) begin
          n_cmp++;
          if (cyc - last_cyc !== 3) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last_cyc);
          end
        end
        last_cyc = cyc; grants++;
      end
      if (ack0 || ack1) begin
        acks++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_sb: unexpected ack %b", {ack1, ack0});
        end else begin
          e = exp_q.pop_front();
          if ({ack1, ack0} !== {e.sel, ~e.sel}) begin
            n_bad++; $display("FAIL b2b_ack: got %b want %b", {ack1, ack0}, {e.sel, ~e.sel});
          end
        end
      end
      prev_en = mem_en;
    end
    n_cmp++;
    if (acks !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d acks want 4", acks); end
    req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore();
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n_cmp++;
    if ({mem_en, busy, ack1, ack0} !== 4'b0000) begin
      n_bad++; $display("FAIL idle_ready: got %b want 0000", {mem_en, busy, ack1, ack0});
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_en, busy, ack1, ack0} !== 4'b0000) begin
      n_bad++; $display("FAIL idle_quiet: got %b want 0000", {mem_en, busy, ack1, ack0});
    end
    req0 = 1'b1; addr0 = 16'h5A5A;
    p = '{sel: 1'b0, addr: 16'h5A5A, err: 1'b0}; exp_q.push_back(p);
    @(negedge clk);
    addr0 = 16'hBEEF; req1 = 1'b1; addr1 = 16'h7777;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, select, mem_addr} !== {1'b1, 1'b0, 16'h5A5A}) begin
      n_bad++; $display("FAIL hold_addr: got %b/%b/%h want 1/0/5a5a", mem_en, select, mem_addr);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; req0 = 1'b0; req1 = 1'b0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++; $display("FAIL hold_sb: queue empty at ack");
    end else begin
      e = exp_q.pop_front();
      if ({ack1, ack0, mem_en} !== {e.sel, ~e.sel, 1'b0}) begin
        n_bad++; $display("FAIL hold_ack: got %b want %b", {ack1, ack0, mem_en}, {e.sel, ~e.sel, 1'b0});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    logic [WIDTH+5:0] obs;
    req1 = 1'b1; addr1 = 16'h0F0F;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, select} !== 2'b11) begin
      n_bad++; $display("FAIL rb_grant: got %b want 11", {mem_en, select});
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    obs = {mem_en, select, ack1, ack0, busy, err_w, mem_addr};
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL rb_abort: got %h want 0", obs); end
    rst = 1'b0; mem_ready = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 16'h1111; addr1 = 16'h2222;
    p = '{sel: 1'b0, addr: 16'h1111, err: 1'b0}; exp_q.push_back(p);
    @(negedge clk);
    n_cmp++;
    if ({mem_en, select, ack1, mem_addr} !== {1'b1, 1'b0, 1'b0, 16'h1111}) begin
      n_bad++; $display("FAIL rb_rr_reset: got %b/%b/%b/%h want 1/0/0/1111", mem_en, select, ack1, mem_addr);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; req0 = 1'b0; req1 = 1'b0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++; $display("FAIL rb_sb: queue empty at ack");
    end else begin
      e = exp_q.pop_front();
      if ({ack1, ack0} !== {e.sel, ~e.sel}) begin
        n_bad++; $display("FAIL rb_ack: got %b want %b", {ack1, ack0}, {e.sel, ~e.sel});
      end
    end
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int en_cycles = 0;
    bit got = 1'b0;
    req1 = 1'b1; addr1 = 16'hC0DE; mem_ready = 1'b0;
    p = '{sel: 1'b1, addr: 16'hC0DE, err: 1'b1}; exp_q.push_back(p);
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (mem_en) en_cycles++;
      n_cmp++;
      if (ack0 || ack1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        if ({ack1, ack0, err_w, mem_en} !== {e.sel, ~e.sel, e.err, 1'b0}) begin
          n_bad++; $display("FAIL to_ack_err: got %b want %b", {ack1, ack0, err_w, mem_en}, {e.sel, ~e.sel, e.err, 1'b0});
        end
      end else if (err_w !== 1'b0) begin
        n_bad++; $display("FAIL to_early_err: err=%b without ack", err_w);
      end
    end
    req1 = 1'b0;
    n_cmp++;
    if (!got || en_cycles != TIMEOUT) begin
      n_bad++; $display("FAIL to_len: got ack=%0d mem_en cycles=%0d want 1/%0d", got, en_cycles, TIMEOUT);
    end
    @(negedge clk);
    n_cmp++;
    if ({err_w, ack1} !== 2'b00) begin n_bad++; $display("FAIL to_pulse: got %b want 00", {err_w, ack1}); end
    req0 = 1'b1; addr0 = 16'hD00D; en_cycles = 0; got = 1'b0;
    p = '{sel: 1'b0, addr: 16'hD00D, err: 1'b0}; exp_q.push_back(p);
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (mem_en) en_cycles++;
      mem_ready = mem_en && (en_cycles == TIMEOUT);
      if (ack0 || ack1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({ack1, ack0, err_w} !== {e.sel, ~e.sel, e.err}) begin
          n_bad++; $display("FAIL to_ready_wins: got %b want %b", {ack1, ack0, err_w}, {e.sel, ~e.sel, e.err});
        end
      end
    end
    req0 = 1'b0; mem_ready = 1'b0;
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL to_ready_seen: no ack within budget"); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_reset_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: %0d expected acks never seen", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
